// File: rtl/cam_reg_sequencer_if.sv
// ---------------------------------------------------------------------------
// cam_reg_sequencer_if
// Bundles the two buses the register sequencer talks to:
//   - init ROM       : o_rom_addr (index out), i_rom_data ({addr,data} back,
//                      one clock after the index changes)
//   - SCCB transmitter: o_tx_start/o_tx_id/o_tx_addr/o_tx_data out,
//                      i_tx_busy/i_tx_nack back
// master = sequencer side, slave = ROM + transmitter side.
// ---------------------------------------------------------------------------
interface cam_reg_sequencer_if #(
    parameter int REG_ADDR_W  = 8,
    parameter int REG_DATA_W  = 8,
    parameter int ROM_DEPTH_W = 8
);
    logic [ROM_DEPTH_W-1:0]           o_rom_addr;
    logic [REG_ADDR_W+REG_DATA_W-1:0] i_rom_data;
    logic                             o_tx_start;
    logic [7:0]                       o_tx_id;
    logic [REG_ADDR_W-1:0]            o_tx_addr;
    logic [REG_DATA_W-1:0]            o_tx_data;
    logic                             i_tx_busy;
    logic                             i_tx_nack;

    modport master (
        output o_rom_addr, o_tx_start, o_tx_id, o_tx_addr, o_tx_data,
        input  i_rom_data, i_tx_busy, i_tx_nack
    );

    modport slave (
        input  o_rom_addr, o_tx_start, o_tx_id, o_tx_addr, o_tx_data,
        output i_rom_data, i_tx_busy, i_tx_nack
    );
endinterface

// File: rtl/cam_reg_sequencer.sv
// ---------------------------------------------------------------------------
// cam_reg_sequencer
// Walks a camera register table in an external ROM and issues one SCCB write
// per entry to the 3-phase write transmitter. Table entries are {addr,data};
// DELAY_ADDR entries pause for data*DELAY_UNIT i_enable ticks, END_ADDR ends
// the walk. NACKed writes are resent up to MAX_RETRY times before the walk
// stops in ERROR.
//
// Ports:
//   clk       system clock
//   i_reset   synchronous active-high reset
//   i_enable  tick used only for delay timing
//   i_start   starts a walk from index 0 (ignored while o_busy)
//   bus       ROM index/data and transmitter request/status (master side)
//   o_busy    high while walking (not IDLE/DONE/ERROR)
//   o_done    table completed
//   o_error   retries exhausted on entry o_index
//   o_index   current or failing table index
// ---------------------------------------------------------------------------
module cam_reg_sequencer #(
    parameter int                    REG_ADDR_W  = 8,
    parameter int                    REG_DATA_W  = 8,
    parameter int                    ROM_DEPTH_W = 8,
    parameter logic [7:0]            DEVICE_ID   = 8'h42,
    parameter logic [REG_ADDR_W-1:0] DELAY_ADDR  = 8'hF0,
    parameter logic [REG_ADDR_W-1:0] END_ADDR    = 8'hFF,
    parameter int                    DELAY_UNIT  = 1000,
    parameter int                    MAX_RETRY   = 3
) (
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_start,
    cam_reg_sequencer_if.master    bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic [ROM_DEPTH_W-1:0] o_index
);

    localparam int DLY_MAX = (2**REG_DATA_W - 1) * DELAY_UNIT;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [ROM_DEPTH_W-1:0] LAST_IDX = '1;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        WAIT_BUSY,
        DELAY,
        NEXT,
        DONE,
        ERROR
    } state_t;

    state_t                  state_q, state_nx;
    logic [ROM_DEPTH_W-1:0]  rom_addr_q, rom_addr_nx;
    logic [REG_ADDR_W-1:0]   tx_addr_q, tx_addr_nx;
    logic [REG_DATA_W-1:0]   tx_data_q, tx_data_nx;
    logic [RTY_W-1:0]        retry_q, retry_nx;
    logic [DLY_W-1:0]        dly_q, dly_nx;
    logic                    seen_busy_q, seen_busy_nx;
    logic                    tx_start;

    logic [REG_ADDR_W-1:0]   rom_a;
    logic [REG_DATA_W-1:0]   rom_d;
    logic [DLY_W-1:0]        dly_load;

    assign rom_a    = bus.i_rom_data[REG_ADDR_W+REG_DATA_W-1 -: REG_ADDR_W];
    assign rom_d    = bus.i_rom_data[REG_DATA_W-1:0];
    // Single multiplier, only consumed in DECODE.
    assign dly_load = DLY_W'(rom_d) * DLY_W'(DELAY_UNIT);

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            tx_addr_q   <= '0;
            tx_data_q   <= '0;
            retry_q     <= '0;
            dly_q       <= '0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_nx;
            rom_addr_q  <= rom_addr_nx;
            tx_addr_q   <= tx_addr_nx;
            tx_data_q   <= tx_data_nx;
            retry_q     <= retry_nx;
            dly_q       <= dly_nx;
            seen_busy_q <= seen_busy_nx;
        end
    end

    always_comb begin
        state_nx     = state_q;
        rom_addr_nx  = rom_addr_q;
        tx_addr_nx   = tx_addr_q;
        tx_data_nx   = tx_data_q;
        retry_nx     = retry_q;
        dly_nx       = dly_q;
        seen_busy_nx = seen_busy_q;
        tx_start     = 1'b0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    rom_addr_nx = '0;
                    state_nx    = FETCH;
                end
            end

            FETCH: state_nx = DECODE;

            DECODE: begin
                if (rom_a == END_ADDR) begin
                    state_nx = DONE;
                end else if (rom_a == DELAY_ADDR) begin
                    if (rom_d == '0) begin
                        state_nx = NEXT;
                    end else begin
                        dly_nx   = dly_load;
                        state_nx = DELAY;
                    end
                end else begin
                    tx_addr_nx = rom_a;
                    tx_data_nx = rom_d;
                    retry_nx   = '0;
                    state_nx   = SEND;
                end
            end

            // Start only toward an idle transmitter; this also covers
            // external back-pressure on i_tx_busy.
            SEND: begin
                if (!bus.i_tx_busy) begin
                    tx_start     = 1'b1;
                    seen_busy_nx = 1'b0;
                    state_nx     = WAIT_BUSY;
                end
            end

            // Two phases: wait for busy to rise, then take the status on the
            // first cycle it is low again.
            WAIT_BUSY: begin
                if (!seen_busy_q) begin
                    if (bus.i_tx_busy) begin
                        seen_busy_nx = 1'b1;
                    end
                end else if (!bus.i_tx_busy) begin
                    if (!bus.i_tx_nack) begin
                        state_nx = NEXT;
                    end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_nx = retry_q + RTY_W'(1);
                        state_nx = SEND;
                    end else begin
                        state_nx = ERROR;
                    end
                end
            end

            DELAY: begin
                if (i_enable) begin
                    dly_nx = dly_q - DLY_W'(1);
                    if (dly_q == DLY_W'(1)) begin
                        state_nx = NEXT;
                    end
                end
            end

            // The last ROM slot ends the walk even without an END marker.
            NEXT: begin
                if (rom_addr_q == LAST_IDX) begin
                    state_nx = DONE;
                end else begin
                    rom_addr_nx = rom_addr_q + ROM_DEPTH_W'(1);
                    state_nx    = FETCH;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // Gating with i_reset drops a pending start in the reset cycle itself.
    assign bus.o_tx_start = tx_start & ~i_reset;
    assign bus.o_tx_id    = DEVICE_ID;
    assign bus.o_tx_addr  = tx_addr_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_rom_addr = rom_addr_q;

    assign o_busy  = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
    assign o_done  = (state_q == DONE);
    assign o_error = (state_q == ERROR);
    assign o_index = rom_addr_q;

endmodule
